// File: rtl/mem_responder.sv
// mem_responder: word-array memory behind a req/ack handshake with WAIT_CYCLES wait states.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to suppress and flag accesses with Address[1:0] != 0.
module mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        wr,
   input  logic [31:0] Address,
   input  logic [31:0] WriteDataMem,
   output logic [31:0] MemData,
   output logic        ack,
   output logic        busy,
   output logic        addr_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         mem_data_q;
   logic                ack_q, busy_q, addr_err_q;
   logic                enter_resp_s;
   logic                err_s;
   logic                mem_we_s;
   logic                mem_rd_s;
   logic                unused_addr_s;
   logic [31:0]         mem_q [2**ADDR_W];

   // Next-state logic; the *_d request fields double as the effective access values,
   // so a zero-wait capture uses the live inputs on the same edge.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_d         = wr_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      enter_resp_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               wr_d    = wr;
               idx_d   = Address[ADDR_W+1:2];
               wdata_d = WriteDataMem;
               if (WAIT_CYCLES == 0) begin
                  state_d      = ST_RESP;
                  enter_resp_s = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d      = ST_RESP;
               enter_resp_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
   logic mis_q, mis_d;

   // Byte-offset capture alongside the other request fields.
   always_comb begin
      if ((state_q == ST_IDLE) && req) begin
         mis_d = (Address[1:0] != 2'b00);
      end else begin
         mis_d = mis_q;
      end
   end

   // Misalignment flag register.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
      end
   end

   assign err_s = mis_d;
`else
   assign err_s = 1'b0;
`endif

   // reset_n gating drops a write that would otherwise land while reset is held
   assign mem_we_s      = enter_resp_s & wr_d & ~err_s & reset_n;
   assign mem_rd_s      = enter_resp_s & ~wr_d & ~err_s;
   assign unused_addr_s = ^{Address[31:ADDR_W+2], Address[1:0]};

   // Control, captured request and registered outputs.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         wr_q       <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= 32'd0;
         mem_data_q <= 32'd0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         ack_q      <= enter_resp_s;
         busy_q     <= (state_d != ST_IDLE);
         addr_err_q <= enter_resp_s & err_s;
         if (mem_rd_s) begin
            mem_data_q <= mem_q[idx_d];
         end else begin
            mem_data_q <= mem_data_q;
         end
      end
   end

   // Word array write port; contents are intentionally not reset.
   always_ff @(posedge Clk) begin
      if (mem_we_s) begin
         mem_q[idx_d] <= wdata_d;
      end
   end

   assign MemData  = mem_data_q;
   assign ack      = ack_q;
   assign busy     = busy_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized check of two mem_responder instances (2 and 0 wait states)
// against an array-based reference model.
module tb_mem_responder;

   logic        Clk;
   logic        reset_n;
   logic        req_a     [2];
   logic        wr_a      [2];
   logic [31:0] addr_a    [2];
   logic [31:0] wd_a      [2];
   logic [31:0] memdata_a [2];
   logic        ack_a     [2];
   logic        busy_a    [2];
   logic        aerr_a    [2];

   logic [31:0] mem_m [2][256];
   logic [31:0] md_m  [2];
   int          n_chk;
   int          n_pass;
   logic        sc_fixed;

   mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut0 (
      .Clk(Clk), .reset_n(reset_n), .req(req_a[0]), .wr(wr_a[0]), .Address(addr_a[0]),
      .WriteDataMem(wd_a[0]), .MemData(memdata_a[0]), .ack(ack_a[0]), .busy(busy_a[0]),
      .addr_err(aerr_a[0]));

   mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut1 (
      .Clk(Clk), .reset_n(reset_n), .req(req_a[1]), .wr(wr_a[1]), .Address(addr_a[1]),
      .WriteDataMem(wd_a[1]), .MemData(memdata_a[1]), .ack(ack_a[1]), .busy(busy_a[1]),
      .addr_err(aerr_a[1]));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One complete transaction; called right after a sample point with the DUT idle.
   task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d);
      int         n;
      int         wexp;
      logic [7:0] idx;
      logic       err;
      wexp = (sel == 0) ? 2 : 0;
      idx  = a[9:2];
      err  = 1'b0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      err  = (a[1:0] != 2'b00);
`endif
      if (!err) begin
         if (w) mem_m[sel][idx] = d;
         else   md_m[sel] = mem_m[sel][idx];
      end
      req_a[sel] = 1'b1; wr_a[sel] = w; addr_a[sel] = a; wd_a[sel] = d;
      @(posedge Clk); #1;
      n = 1;
      while (!ack_a[sel] && n < 40) begin
         check_val("busy_wait", {31'd0, busy_a[sel]}, 32'd1);
         if (sc_fixed) begin
            addr_a[sel] = 32'h80; wd_a[sel] = 32'h0;
         end else begin
            req_a[sel] = 1'($urandom); wr_a[sel] = 1'($urandom);
            addr_a[sel] = $urandom; wd_a[sel] = $urandom;
         end
         @(posedge Clk); #1;
         n++;
      end
      req_a[sel] = 1'b0;
      check_val("ack_latency", n, wexp + 1);
      check_val("busy_at_ack", {31'd0, busy_a[sel]}, 32'd1);
      check_val("memdata", memdata_a[sel], md_m[sel]);
      check_val("addr_err", {31'd0, aerr_a[sel]}, {31'd0, err});
      @(posedge Clk); #1;
      check_val("ack_clear", {31'd0, ack_a[sel]}, 32'd0);
      check_val("busy_clear", {31'd0, busy_a[sel]}, 32'd0);
      check_val("aerr_clear", {31'd0, aerr_a[sel]}, 32'd0);
   endtask

   initial begin
      logic [31:0] prior;
      n_chk = 0; n_pass = 0; sc_fixed = 1'b0;
      for (int s = 0; s < 2; s++) begin
         req_a[s] = 1'b0; wr_a[s] = 1'b0; addr_a[s] = 32'd0; wd_a[s] = 32'd0; md_m[s] = 32'd0;
      end
      reset_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check_val("rst_memdata", memdata_a[s], 32'd0);
         check_val("rst_ack", {31'd0, ack_a[s]}, 32'd0);
         check_val("rst_busy", {31'd0, busy_a[s]}, 32'd0);
         check_val("rst_aerr", {31'd0, aerr_a[s]}, 32'd0);
      end
      reset_n = 1'b1;
      @(posedge Clk); #1;

      // preload every word of both arrays so all later reads have a known answer
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 256; i++) access(s, 1'b1, i * 4, $urandom);
      end

      // write then read with latency check
      access(0, 1'b1, 32'h40, 32'hCAFEF00D);
      access(0, 1'b0, 32'h40, 32'h0);
      check_val("rd_cafef00d", memdata_a[0], 32'hCAFEF00D);
      @(posedge Clk); #1;
      check_val("rd_held", memdata_a[0], 32'hCAFEF00D);

      // reset one cycle after capturing a write
      prior = mem_m[0][4];
      req_a[0] = 1'b1; wr_a[0] = 1'b1; addr_a[0] = 32'h10; wd_a[0] = 32'hDEADBEEF;
      @(posedge Clk); #1;
      req_a[0] = 1'b0;
      @(posedge Clk); #1;
      reset_n = 1'b0;
      #1;
      check_val("midrst_busy", {31'd0, busy_a[0]}, 32'd0);
      check_val("midrst_memdata", memdata_a[0], 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge Clk); #1;
         check_val("midrst_ack", {31'd0, ack_a[0]}, 32'd0);
      end
      reset_n = 1'b1;
      md_m[0] = 32'd0; md_m[1] = 32'd0;
      @(posedge Clk); #1;
      check_val("postrst_ack", {31'd0, ack_a[0]}, 32'd0);
      check_val("postrst_busy", {31'd0, busy_a[0]}, 32'd0);
      access(0, 1'b0, 32'h10, 32'h0);
      check_val("midrst_discard", memdata_a[0], prior);

      // inputs changed while busy are ignored
      prior = mem_m[0][32];
      sc_fixed = 1'b1;
      access(0, 1'b1, 32'h08, 32'h12345678);
      sc_fixed = 1'b0;
      access(0, 1'b0, 32'h08, 32'h0);
      check_val("ignore_busy_08", memdata_a[0], 32'h12345678);
      access(0, 1'b0, 32'h80, 32'h0);
      check_val("ignore_busy_80", memdata_a[0], prior);

      // aliasing above the index bits
      access(0, 1'b1, 32'h404, 32'hA5A5A5A5);
      access(0, 1'b0, 32'h004, 32'h0);
      check_val("alias", memdata_a[0], 32'hA5A5A5A5);

      // zero wait, req held high for two reads
      access(1, 1'b1, 32'h0, 32'h11111111);
      access(1, 1'b1, 32'h4, 32'h22222222);
      req_a[1] = 1'b1; wr_a[1] = 1'b0; addr_a[1] = 32'h0;
      @(posedge Clk); #1;
      check_val("b2b_ack0", {31'd0, ack_a[1]}, 32'd1);
      check_val("b2b_data0", memdata_a[1], 32'h11111111);
      addr_a[1] = 32'h4;
      @(posedge Clk); #1;
      check_val("b2b_gap_ack", {31'd0, ack_a[1]}, 32'd0);
      check_val("b2b_gap_busy", {31'd0, busy_a[1]}, 32'd0);
      @(posedge Clk); #1;
      req_a[1] = 1'b0;
      check_val("b2b_ack1", {31'd0, ack_a[1]}, 32'd1);
      check_val("b2b_data1", memdata_a[1], 32'h22222222);
      md_m[1] = 32'h22222222;
      @(posedge Clk); #1;
      check_val("b2b_idle", {31'd0, busy_a[1]}, 32'd0);

      // misaligned write
      prior = mem_m[0][2];
      access(0, 1'b1, 32'h0A, 32'h99999999);
      access(0, 1'b0, 32'h08, 32'h0);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      check_val("align_suppressed", memdata_a[0], prior);
`else
      check_val("align_ignored", memdata_a[0], 32'h99999999);
`endif

      // randomized traffic on both instances
      for (int i = 0; i < 120; i++) begin
         access(i % 3 == 0 ? 1 : 0, 1'($urandom), $urandom_range(0, 4095), $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
